ras_driver: RTL
===============

# ras_driver

Front-end control block that drives the return-address-stack request interface. It decodes call/return events from fetch and issues push/pop with the computed return address. It tracks per-stage RAS operation groups as the pipeline advances, converting backend advance/redirect events into the RAS `commit`/`flush` pulse vectors. It also returns registered return-target predictions to fetch.

## Interface
- `STAGES`, 2, speculative pipeline stages tracked; must match the RAS instance.
- `WIDTH`, 31, address width in halfword units (byte address >> 1).
- `MAX_OPS`, 16, maximum RAS ops per stage group; must not exceed the RAS scratchpad depth.
- `SW`, `$clog2(STAGES)` (minimum 1), width of the redirect stage index (localparam).

Ports:
- `clk` in 1: clock.
- `rst_i` in 1: one clock; reset is synchronous and active-high.
- `fe_valid` in 1: fetch presents an instruction.
- `fe_ready` out 1: instruction accepted when `fe_valid && fe_ready`.
- `fe_call` in 1: instruction is a call.
- `fe_ret` in 1: instruction is a return.
- `fe_rvc` in 1: instruction is 16-bit.
- `fe_pc` in WIDTH: instruction address.
- `be_adv` in STAGES: bit i is a one-cycle pulse; the group in stage i moves to i+1, or retires when i = STAGES-1.
- `be_redirect` in 1: misprediction pulse.
- `be_redirect_stage` in SW: stage index s of the mispredicting instruction.
- `push`, `pop` out 1: RAS requests.
- `din` out WIDTH: RAS push data.
- `commit`, `flush` out STAGES: RAS group control.
- `ras_dout` in WIDTH, `ras_valid` in 1: RAS top-of-stack read.
- `pred_valid` out 1, `pred_hit` out 1, `pred_target` out WIDTH: return prediction.

## Operation
- FSM states:
  - RESET: entered on `rst_i`; stays 2 cycles after `rst_i` falls, covering the RAS registered reset, then RUN.
  - RUN: normal operation.
  - RECOVER: entered on `be_redirect`; lasts 1 cycle, then RUN.
- `rst_i` mid-operation: all state is cleared next edge, including any pending RECOVER.
- Accept:
  - `fe_ready = (state==RUN) && !be_redirect && (cnt[0] < MAX_OPS || be_adv[0])`.
  - The `be_redirect -> fe_ready` path is combinational by design.
- On accept, combinationally in the same cycle:
  - `push = fe_call`, `pop = fe_ret`.
  - Call and return together (coroutine swap) assert both, which replaces the top of stack.
  - Neither bit set: no RAS op, and counters are unchanged.
- `din = fe_pc + (fe_rvc ? 1 : 2)`, computed modulo 2^WIDTH so the address wraps. `din` is driven every cycle; it is only meaningful while `push` is high.
- Per-stage counters `cnt[i]`, width `$clog2(MAX_OPS+1)`, count RAS ops (push, pop, or swap = 1 op) in group i. Update rule:
  - `cnt[0]_next = (be_adv[0] ? 0 : cnt[0]) + op`.
  - `cnt[i]_next = (be_adv[i] ? 0 : cnt[i]) + (be_adv[i-1] ? cnt[i-1] : 0)`.
  - A sum exceeding MAX_OPS is a protocol violation (assertion), not a clamp.
- `commit[i] = be_adv[i] && (cnt[i] != 0)`: empty groups are never committed.
- Redirect with stage s:
  - `flush[j] = 1` for all j <= s; `cnt[0..s]` cleared.
  - `commit[j]` is masked for j <= s; `be_adv[s]` contents are not added to stage s+1.
  - Stages above s advance and commit normally in the same cycle.
  - s >= STAGES is treated as STAGES-1.
- Prediction: on an accepted return, `pred_target <= ras_dout` and `pred_hit <= ras_valid`, i.e. the pre-pop top. `pred_valid <= 1` for exactly one cycle. Otherwise `pred_valid <= 0`, and `pred_target`/`pred_hit` hold.

## Timing
- Reset values: `fe_ready=0`, `push=pop=0`, `commit=flush=0`, `pred_valid=0`, `pred_hit=0`, `pred_target=0`, all `cnt=0`, state RESET.
- `fe_ready` is first high on the 3rd edge after `rst_i` is sampled low.
- `push`/`pop`/`din`/`commit`/`flush` are combinational in the accept/event cycle, with zero latency into the RAS.
- `pred_*` has 1-cycle latency after accept.
- After `be_redirect` at cycle t:
  - `fe_ready` is low in cycles t and t+1 (RECOVER).
  - First accept is possible at t+2; `ras_dout` reflects the restored top from t+1.
- Backpressure: with `cnt[0]==MAX_OPS` and no `be_adv[0]`, `fe_ready` stays low even for non-RAS instructions.

## Test plan
- Reset release, then call at `fe_pc=0x100` with `fe_rvc=0`:
  - `fe_ready` rises on the 3rd edge after `rst_i` falls.
  - `push=1`, `din=0x102`, `cnt[0]=1` next cycle.
- Call at `pc=0x200` with `rvc=1`, then `be_adv=2'b01`, then `be_adv=2'b10`, then a return:
  - `commit=01`, then `commit=10`.
  - `pop=1`; next cycle `pred_valid=1`, `pred_target=0x201`, `pred_hit=1`.
- Three calls, then `be_adv[0]` pulse, then one call, then `be_redirect` with s=0:
  - `flush=01`, `cnt[0]=0`, `cnt[1]=3`.
  - `fe_ready` is low for 2 cycles.
  - The next return predicts the 3rd call's address.
- Redirect with s=1 in the same cycle as `be_adv=2'b11`:
  - `flush=11`, `commit=00`, all counters 0.
- Fill `cnt[0]` to 16 calls:
  - `fe_ready` drops.
  - Asserting `be_adv[0]` re-enables accept in the same cycle and gives `cnt[0]=1` after the next call.
- Swap with `fe_call=fe_ret=1`, `pc=0x7FFFFFFF`, `rvc=0`:
  - `push=pop=1`, `din=0x00000001` (wrap).
  - Counter increments by exactly 1.

Source files
------------

// File: rtl/ras_driver.sv
// Return-address-stack driver: decodes fetch call/return into push/pop, tracks
// per-stage RAS op groups for commit/flush, and registers return predictions.
module ras_driver #(
   parameter int STAGES  = 2,
   parameter int WIDTH   = 31,
   parameter int MAX_OPS = 16,
   localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic              fe_valid,
   output logic              fe_ready,
   input  logic              fe_call,
   input  logic              fe_ret,
   input  logic              fe_rvc,
   input  logic [WIDTH-1:0]  fe_pc,
   input  logic [STAGES-1:0] be_adv,
   input  logic              be_redirect,
   input  logic [SW-1:0]     be_redirect_stage,
   output logic              push,
   output logic              pop,
   output logic [WIDTH-1:0]  din,
   output logic [STAGES-1:0] commit,
   output logic [STAGES-1:0] flush,
   input  logic [WIDTH-1:0]  ras_dout,
   input  logic              ras_valid,
   output logic              pred_valid,
   output logic              pred_hit,
   output logic [WIDTH-1:0]  pred_target
);

   localparam int CW = $clog2(MAX_OPS + 1);
   localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);

   typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_RECOVER} state_t;

   state_t            state, state_next;
   logic [1:0]        rst_cnt, rst_cnt_next;
   logic              accept;
   logic              op;
   logic [SW-1:0]     s_eff;
   logic [STAGES-1:0] flushed;
   logic [CW-1:0]     cnt     [STAGES];
   logic [CW:0]       cnt_sum [STAGES];

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state   <= ST_RESET;
         rst_cnt <= 2'd0;
      end else begin
         state   <= state_next;
         rst_cnt <= rst_cnt_next;
      end
   end

   // RESET holds for two sampled-low edges so the RAS finishes its own reset.
   always_comb begin
      state_next   = state;
      rst_cnt_next = rst_cnt;
      case (state)
         ST_RESET: begin
            if (rst_cnt == 2'd2) state_next = ST_RUN;
            else                 rst_cnt_next = rst_cnt + 2'd1;
         end
         ST_RUN:     if (be_redirect) state_next = ST_RECOVER;
         ST_RECOVER: state_next = be_redirect ? ST_RECOVER : ST_RUN;
         default:    state_next = ST_RESET;
      endcase
   end

   always_comb begin
      fe_ready = (state == ST_RUN) && !be_redirect &&
                 ((cnt[0] < CW'(MAX_OPS)) || be_adv[0]);
      accept   = fe_valid && fe_ready;
      push     = accept && fe_call;
      pop      = accept && fe_ret;
      op       = accept && (fe_call || fe_ret);
   end

   assign din = fe_pc + (fe_rvc ? WIDTH'(1) : WIDTH'(2));

   // A group advancing out of a flushed stage is dropped rather than carried up.
   always_comb begin
      logic [CW:0] carry;
      carry   = '0;
      s_eff   = (be_redirect_stage > LAST_STAGE) ? LAST_STAGE : be_redirect_stage;
      for (int i = 0; i < STAGES; i++) begin
         flushed[i] = be_redirect && (i <= int'(s_eff));
         commit[i]  = be_adv[i] && (cnt[i] != '0) && !flushed[i];
      end
      flush = flushed;
      cnt_sum[0] = flushed[0] ? '0 :
                   ((be_adv[0] ? '0 : {1'b0, cnt[0]}) + (CW+1)'(op));
      for (int i = 1; i < STAGES; i++) begin
         carry      = (be_adv[i-1] && !flushed[i-1]) ? {1'b0, cnt[i-1]} : '0;
         cnt_sum[i] = flushed[i] ? '0 :
                      ((be_adv[i] ? '0 : {1'b0, cnt[i]}) + carry);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) cnt[i] <= cnt_sum[i][CW-1:0];
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_chk
      a_no_overflow: assert property (@(posedge clk) disable iff (rst_i)
         cnt_sum[g] <= (CW+1)'(MAX_OPS));
   end

   // Prediction captures the top of stack as it was before this pop.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         pred_valid  <= 1'b0;
         pred_hit    <= 1'b0;
         pred_target <= '0;
      end else if (accept && fe_ret) begin
         pred_valid  <= 1'b1;
         pred_hit    <= ras_valid;
         pred_target <= ras_dout;
      end else begin
         pred_valid  <= 1'b0;
      end
   end

endmodule
